// File: rtl/vedic_mult_pipe.sv
// Four-stage Urdhva-Tiryagbhyam multiplier with valid/ready flow control.
// Optional dot-product accumulator enabled by VEDIC_MULT_PIPE_ACC_EN.
module vedic_mult_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          signed_mode,
  input  logic                          acc_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WIDTH-1:0]            result,
  output logic                          acc_valid,
  output logic [2*WIDTH+ACC_GUARD-1:0]  acc_out
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + ACC_GUARD;

  logic             w_advance;
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH-1:0] w_pp_hh, w_pp_lh, w_pp_hl, w_pp_ll;
  logic [WIDTH:0]   w_cross;
  logic [WIDTH:0]   w_mid;
  logic [WIDTH-1:0] w_hi;
  logic [PW-1:0]    w_full;
  logic [PW-1:0]    w_prod;

  logic             r_v1, r_sign1, r_sm1, r_last1;
  logic [WIDTH-1:0] r_hh1, r_lh1, r_hl1, r_ll1;
  logic             r_v2, r_sign2, r_sm2, r_last2;
  logic [WIDTH-1:0] r_hh2, r_ll2;
  logic [WIDTH:0]   r_cross2;
  logic             r_v3, r_sign3, r_sm3, r_last3;
  logic [WIDTH-1:0] r_hh3;
  logic [WIDTH:0]   r_mid3;
  logic [H-1:0]     r_lo3;
  logic             r_v4, r_sm4, r_last4;
  logic [PW-1:0]    r_result;

  assign w_advance = !r_v4 || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_v4;
  assign result    = r_result;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  assign w_neg_a = signed_mode & a[WIDTH-1];
  assign w_neg_b = signed_mode & b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -a : a;
  assign w_mag_b = w_neg_b ? -b : b;

  assign w_pp_hh = {{H{1'b0}}, w_mag_a[WIDTH-1:H]} * {{H{1'b0}}, w_mag_b[WIDTH-1:H]};
  assign w_pp_lh = {{H{1'b0}}, w_mag_a[H-1:0]}     * {{H{1'b0}}, w_mag_b[WIDTH-1:H]};
  assign w_pp_hl = {{H{1'b0}}, w_mag_a[WIDTH-1:H]} * {{H{1'b0}}, w_mag_b[H-1:0]};
  assign w_pp_ll = {{H{1'b0}}, w_mag_a[H-1:0]}     * {{H{1'b0}}, w_mag_b[H-1:0]};

  assign w_cross = {1'b0, r_lh1} + {1'b0, r_hl1};
  assign w_mid   = r_cross2 + {{(H+1){1'b0}}, r_ll2[WIDTH-1:H]};
  assign w_hi    = r_hh3 + {{(H-1){1'b0}}, r_mid3[WIDTH:H]};
  assign w_full  = {w_hi, r_mid3[H-1:0], r_lo3};
  assign w_prod  = r_sign3 ? -w_full : w_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v1     <= 1'b0;
      r_sign1  <= 1'b0;
      r_sm1    <= 1'b0;
      r_last1  <= 1'b0;
      r_hh1    <= '0;
      r_lh1    <= '0;
      r_hl1    <= '0;
      r_ll1    <= '0;
      r_v2     <= 1'b0;
      r_sign2  <= 1'b0;
      r_sm2    <= 1'b0;
      r_last2  <= 1'b0;
      r_hh2    <= '0;
      r_ll2    <= '0;
      r_cross2 <= '0;
      r_v3     <= 1'b0;
      r_sign3  <= 1'b0;
      r_sm3    <= 1'b0;
      r_last3  <= 1'b0;
      r_hh3    <= '0;
      r_mid3   <= '0;
      r_lo3    <= '0;
      r_v4     <= 1'b0;
      r_sm4    <= 1'b0;
      r_last4  <= 1'b0;
      r_result <= '0;
    end else if (w_advance) begin
      r_v1     <= in_valid;
      r_sign1  <= w_neg_a ^ w_neg_b;
      r_sm1    <= signed_mode;
      r_last1  <= acc_last;
      r_hh1    <= w_pp_hh;
      r_lh1    <= w_pp_lh;
      r_hl1    <= w_pp_hl;
      r_ll1    <= w_pp_ll;

      r_v2     <= r_v1;
      r_sign2  <= r_sign1;
      r_sm2    <= r_sm1;
      r_last2  <= r_last1;
      r_hh2    <= r_hh1;
      r_ll2    <= r_ll1;
      r_cross2 <= w_cross;

      r_v3     <= r_v2;
      r_sign3  <= r_sign2;
      r_sm3    <= r_sm2;
      r_last3  <= r_last2;
      r_hh3    <= r_hh2;
      r_mid3   <= w_mid;
      r_lo3    <= r_ll2[H-1:0];

      r_v4     <= r_v3;
      r_sm4    <= r_sm3;
      r_last4  <= r_last3;
      r_result <= w_prod;
    end
  end

`ifdef VEDIC_MULT_PIPE_ACC_EN
  logic          w_consume;
  logic [AW-1:0] w_ext;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_acc_out;
  logic          r_acc_valid;

  assign w_consume = r_v4 && out_ready;
  assign w_ext     = r_sm4 ? {{ACC_GUARD{r_result[PW-1]}}, r_result}
                           : {{ACC_GUARD{1'b0}}, r_result};
  assign w_sum     = r_acc + w_ext;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      r_acc_valid <= 1'b0;
      if (w_consume) begin
        if (r_last4) begin
          r_acc_out   <= w_sum;
          r_acc_valid <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign acc_valid = r_acc_valid;
  assign acc_out   = r_acc_out;
`else
  // Tags still ride the pipeline in this build; the outputs stay pinned at zero.
  assign acc_valid = 1'b0 & (r_last4 | r_sm4);
  assign acc_out   = {AW{1'b0}};
`endif

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe: vector table, stream, stall, reset and
// accumulator sequences against a queue scoreboard.
module tb_vedic_mult_pipe;

  localparam int W  = 16;
  localparam int G  = 8;
  localparam int AW = 2*W + G;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic            signed_mode = 1'b0;
  logic            acc_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*W-1:0]  result;
  logic            acc_valid;
  logic [AW-1:0]   acc_out;

  vedic_mult_pipe #(.WIDTH(W), .ACC_GUARD(G)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .acc_valid(acc_valid), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] pend_exp;
  int             run_len = 0;
  int             max_run = 0;
  int             acc_pulses = 0;
  logic [AW-1:0]  acc_seen = '0;
  int             stall_in = 0;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    bit             sm;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input bit sm);
    longint sa, sb, p;
    sa = sm ? longint'($signed(ma)) : longint'(ma);
    sb = sm ? longint'($signed(mb)) : longint'(mb);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Scoreboard: compare before the edge that consumes, push before the edge that accepts.
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      run_len = 0;
    end else begin
      if (out_valid && out_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", result);
        end else begin
          chk("result", {32'h0, result}, {32'h0, sb_q.pop_front()});
        end
      end else begin
        run_len = 0;
      end
      if (in_valid && in_ready) sb_q.push_back(pend_exp);
      if (acc_valid) begin
        acc_pulses++;
        acc_seen = acc_out;
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit sm,
                      input bit last, input logic [2*W-1:0] exp);
    int n;
    n = 0;
    a = ta; b = tb; signed_mode = sm; acc_last = last; pend_exp = exp; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      stall_in++;
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [2*W-1:0] held;
  int             cnt;
  int             seen;
  bit             rnd_done;
  logic [W-1:0]   ra, rb;
  bit             rs;

  initial begin
    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[1]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[2]  = '{16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD};
    vecs[3]  = '{16'h0000, 16'h8000, 1'b1, 32'h00000000};
    vecs[4]  = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    vecs[6]  = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vecs[9]  = '{16'hFFFF, 16'h0000, 1'b1, 32'h00000000};
    vecs[10] = '{16'hABCD, 16'h0001, 1'b1, 32'hFFFFABCD};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_acc_valid", 64'(acc_valid), 64'd0);
    chk("rst_acc_out", 64'(acc_out), 64'd0);
    @(posedge clk); #1;

    // Latency of a single beat
    a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b0; pend_exp = 32'hFFFE0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", 64'(cnt), 64'd4);
    drain();

    for (int i = 0; i < 11; i++) send(vecs[i].va, vecs[i].vb, vecs[i].sm, 1'b0, vecs[i].exp);
    drain();

    // Back-to-back stream
    stall_in = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) send(16'(i + 1), 16'h0100, 1'b0, 1'b0, 32'(32'h100 * (i + 1)));
    drain();
    chk("stream_in_ready", 64'(stall_in), 64'd0);
    chk("stream_run", 64'(max_run >= 8), 64'd1);

    // Backpressure window mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
          send(ra, rb, rs, 1'b0, model(ra, rb, rs));
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = result;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_result", 64'(result), 64'(held));
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
          send(ra, rb, rs, 1'b0, model(ra, rb, rs));
        end
        rnd_done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000 && !rnd_done; k++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight
    send(16'h0011, 16'h0022, 1'b0, 1'b0, 32'h00000242);
    send(16'h0033, 16'h0044, 1'b0, 1'b0, 32'h00000D8C);
    send(16'h0055, 16'h0066, 1'b0, 1'b0, 32'h000021DE);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rr_out_valid", 64'(out_valid), 64'd0);
    chk("rr_result", 64'(result), 64'd0);
    chk("rr_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rr_quiet", 64'(seen), 64'd0);
    @(posedge clk); #1;

`ifdef VEDIC_MULT_PIPE_ACC_EN
    acc_pulses = 0;
    send(16'd3, 16'd4, 1'b1, 1'b0, 32'd12);
    send(16'hFFFE, 16'd5, 1'b1, 1'b0, 32'hFFFFFFF6);
    send(16'd7, 16'hFFFF, 1'b1, 1'b1, 32'hFFFFFFF9);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("acc_pulses", 64'(acc_pulses), 64'd1);
    chk("acc_sum", 64'(acc_seen), 64'(40'hFFFFFFFFFB));
    send(16'd1, 16'd2, 1'b1, 1'b1, 32'd2);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("acc_pulses2", 64'(acc_pulses), 64'd2);
    chk("acc_restart", 64'(acc_seen), 64'd2);
`else
    send(16'd3, 16'd4, 1'b1, 1'b1, 32'd12);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("acc_off_pulses", 64'(acc_pulses), 64'd0);
    chk("acc_off_out", 64'(acc_out), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised, fully pipelined unsigned/signed Vedic (Urdhva-Tiryagbhyam) multiplier for the systolic-array datapath.
- Successor to the fixed 16x16 quarter-split multiplier. Adds:
  - generic WIDTH
  - per-beat signed mode
  - valid/ready handshake with backpressure
  - optional dot-product accumulator
- Sits between the operand skew buffers and the PE output registers.

Parameters:
- WIDTH, 16, operand width; even, 4..32.
- ACC_GUARD, 8, extra accumulator bits above 2*WIDTH (used only with the accumulator feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = two's-complement a, b; 0 = unsigned; sampled with the beat
- acc_last  input  1  beat closes a dot product (accumulator feature only; ignored otherwise)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH  product of the beat
- acc_valid  output  1  accumulated sum valid (accumulator feature only; else constant 0)
- acc_out  output  2*WIDTH+ACC_GUARD  accumulated signed/unsigned sum (else constant 0)

Behaviour:
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - Global advance = !out_valid | out_ready; in_ready = advance (combinational).
  - Whole pipeline freezes while !advance; no beat is dropped or duplicated.
- Latency: exactly 4 advancing cycles from acceptance to out_valid. Throughput is 1 beat/cycle with out_ready held high.
- Pipeline stages, with H = WIDTH/2:
  - S1: sign handling. In signed mode, take magnitudes of a and b; sign = a_msb ^ b_msb. Register the four HxH partial products hh, lh, hl, ll, plus sign and the acc_last tag.
  - S2: cross = lh + hl, (H*2+1) bits. Pass hh and ll through unchanged.
  - S3: mid = cross + ll[2H-1:H]. Pass hh and ll[H-1:0] through.
  - S4: full = {hh + mid[top:H], mid[H-1:0], ll[H-1:0]}. If sign, result = -full (two's complement, 2*WIDTH bits); else result = full.
  - Truncation at every stage is to the exact width needed; there is no overflow, since the product always fits in 2*WIDTH bits.
- Boundary values:
  - Signed -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - Signed (-2^(W-1))^2 = 2^(2W-2) is exact.
  - Zero times anything gives 0 with no negative zero.
- Per-stage valid bits shift on advance. out_valid = S4 valid.
- Reset (synchronous, reset==0 at a clk edge):
  - All valid bits cleared.
  - result = 0, out_valid = 0, acc_valid = 0, acc_out = 0.
  - Data registers are also cleared.
  - in_ready = 1 on the first cycle after reset deasserts.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted afterwards.
- Simultaneous accept and output while out_valid & out_ready: legal. The pipeline shifts and the new beat enters S1 in the same cycle.

Optional Feature:
- Macro: VEDIC_MULT_PIPE_ACC_EN.
- When defined:
  - On each consumed result (out_valid & out_ready), acc_reg += sign-extended result. Sign extension applies in signed mode; zero extension in unsigned mode.
  - If that beat carries acc_last: acc_out <= acc_reg + result and acc_valid pulses for 1 cycle; acc_reg then restarts at 0 for the next beat.
  - acc_reg wraps modulo 2^(2*WIDTH+ACC_GUARD).
  - Reset clears acc_reg, acc_out and acc_valid.
  - A stall holds the accumulator unchanged.
- When undefined: no accumulator logic; acc_valid and acc_out are tied 0; acc_last is ignored.

Test Plan:
- WIDTH=16, unsigned, out_ready=1. Feed a=0xFFFF, b=0xFFFF. -> out_valid 4 cycles later, result=0xFFFE0001.
- Signed beats with out_ready=1:
  - a=0x8000, b=0x8000 -> result=0x40000000.
  - a=0xFFFF (-1), b=0x0003 -> result=0xFFFFFFFD.
  - a=0, b=0x8000 -> result=0.
- Back-to-back stream of 8 beats (a=i+1, b=0x0100, i=0..7) with out_ready=1. -> 8 consecutive out_valid cycles, result=0x100*(i+1), in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles mid-stream. -> out_valid/result held stable, in_ready=0 while out_valid=1, and no beats are lost or duplicated after release; compare with a reference-model scoreboard.
- Reset: assert reset=0 with 3 beats in flight, release after 2 cycles. -> out_valid=0, result=0 and in_ready=1 after release, and the in-flight beats are never emitted.
- Accumulator (VEDIC_MULT_PIPE_ACC_EN, signed): beats (3,4), (-2,5), (7,-1) with acc_last on the third. -> a single acc_valid pulse with acc_out=-5 (all ones in the upper bits); the next sum starts from 0.
